// File: rtl/ex_operand_forward_unit_if.sv
// Operand-forwarding bus between the ID stage, the downstream producers
// (EX/MEM, MEM/WB) and the ID/EX operand registers.
//   ID side      : id_valid, id_rs1/rs2, id_rs1/rs2_data, id_imm, id_alu_src, flush
//   Producers    : exmem_we/rd/data/is_load, memwb_we/rd/data
//   EX side      : stall, ex_valid, ex_op1, ex_op2, ex_store_data, ex_fwd_sel1/2
//   Statistics   : stat_fwd_cnt, stat_stall_cnt (only with FWD_STATS_EN defined)
// master = pipeline side driving the inputs; slave = the forwarding unit.
interface ex_operand_forward_unit_if #(
  parameter int XLEN         = 32,
  parameter int REG_AW       = 5,
  parameter int BYPASS_DEPTH = 3
);
  localparam int SELW = $clog2(BYPASS_DEPTH + 1);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic              id_alu_src;
  logic              flush;
  logic              exmem_we;
  logic [REG_AW-1:0] exmem_rd;
  logic [XLEN-1:0]   exmem_data;
  logic              exmem_is_load;
  logic              memwb_we;
  logic [REG_AW-1:0] memwb_rd;
  logic [XLEN-1:0]   memwb_data;
  logic              stall;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_op1;
  logic [XLEN-1:0]   ex_op2;
  logic [XLEN-1:0]   ex_store_data;
  logic [SELW-1:0]   ex_fwd_sel1;
  logic [SELW-1:0]   ex_fwd_sel2;
`ifdef FWD_STATS_EN
  logic [31:0]       stat_fwd_cnt;
  logic [31:0]       stat_stall_cnt;
`endif

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_imm,
           id_alu_src, flush, exmem_we, exmem_rd, exmem_data, exmem_is_load,
           memwb_we, memwb_rd, memwb_data,
    input  stall, ex_valid, ex_op1, ex_op2, ex_store_data, ex_fwd_sel1,
           ex_fwd_sel2
`ifdef FWD_STATS_EN
    , input stat_fwd_cnt, stat_stall_cnt
`endif
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_imm,
           id_alu_src, flush, exmem_we, exmem_rd, exmem_data, exmem_is_load,
           memwb_we, memwb_rd, memwb_data,
    output stall, ex_valid, ex_op1, ex_op2, ex_store_data, ex_fwd_sel1,
           ex_fwd_sel2
`ifdef FWD_STATS_EN
    , output stat_fwd_cnt, stat_stall_cnt
`endif
  );
endinterface

// File: rtl/ex_operand_forward_unit.sv
// ID->EX operand bypass and capture stage.
// Selects each of rs1/rs2 from EX/MEM, MEM/WB, a post-writeback history
// buffer or the register file (youngest producer wins, x0 never forwarded),
// detects load-use hazards (stall, combinational) and registers the chosen
// operands into the ID/EX registers.
// Ports: clk, rst_n (async, active low), bus (ex_operand_forward_unit_if.slave).
// Select codes: 0 RF, 1 EX/MEM, 2 MEM/WB, 3+k history entry k (0 = newest).
// Optional macro FWD_STATS_EN: adds saturating stat_fwd_cnt / stat_stall_cnt.
module ex_operand_forward_unit #(
  parameter int XLEN         = 32,
  parameter int REG_AW       = 5,
  parameter int BYPASS_DEPTH = 3
) (
  input logic                     clk,
  input logic                     rst_n,
  ex_operand_forward_unit_if.slave bus
);
  localparam int SELW = $clog2(BYPASS_DEPTH + 1);
  localparam int HIST = BYPASS_DEPTH - 2;
  localparam int HN   = (HIST > 0) ? HIST : 1;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } hist_t;

  hist_t             hist [HN];
  logic [REG_AW-1:0] rs   [2];
  logic [XLEN-1:0]   rf   [2];
  logic [SELW-1:0]   sel  [2];
  logic [XLEN-1:0]   val  [2];
  logic              stall_c;

  logic              ex_valid_q;
  logic [XLEN-1:0]   op1_q;
  logic [XLEN-1:0]   op2_q;
  logic [XLEN-1:0]   store_q;
  logic [SELW-1:0]   sel1_q;
  logic [SELW-1:0]   sel2_q;

  assign rs[0] = bus.id_rs1;
  assign rs[1] = bus.id_rs2;
  assign rf[0] = bus.id_rs1_data;
  assign rf[1] = bus.id_rs2_data;

  // History buffer: retired MEM/WB writes, shifted every cycle regardless of
  // stall/flush so a stalled consumer still sees values that already left WB.
  generate
    if (HIST > 0) begin : g_hist
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned k = 0; k < HIST; k++) hist[k] <= '0;
        end else begin
          hist[0] <= '{valid: bus.memwb_we && (bus.memwb_rd != '0),
                       rd:    bus.memwb_rd,
                       data:  bus.memwb_data};
          for (int unsigned k = 1; k < HIST; k++) hist[k] <= hist[k-1];
        end
      end
    end else begin : g_no_hist
      assign hist[0] = '0;
    end
  endgenerate

  // Priority is realised by evaluating producers oldest-first and letting
  // each younger match overwrite the previous selection.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      sel[i] = '0;
      val[i] = rf[i];
      if (rs[i] != '0) begin
        for (int unsigned j = 0; j < HIST; j++) begin
          if (hist[HIST-1-j].valid && (hist[HIST-1-j].rd == rs[i])) begin
            sel[i] = SELW'(3 + HIST - 1 - j);
            val[i] = hist[HIST-1-j].data;
          end
        end
        if (bus.memwb_we && (bus.memwb_rd == rs[i])) begin
          sel[i] = SELW'(2);
          val[i] = bus.memwb_data;
        end
        if (bus.exmem_we && (bus.exmem_rd == rs[i])) begin
          sel[i] = SELW'(1);
          val[i] = bus.exmem_data;
        end
      end
    end
  end

  // rs2 is always checked: it feeds store data even when op2 is the immediate.
  assign stall_c = bus.id_valid && bus.exmem_is_load && bus.exmem_we &&
                   (bus.exmem_rd != '0) &&
                   ((bus.exmem_rd == bus.id_rs1) || (bus.exmem_rd == bus.id_rs2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      op1_q      <= '0;
      op2_q      <= '0;
      store_q    <= '0;
      sel1_q     <= '0;
      sel2_q     <= '0;
    end else if (bus.flush || stall_c) begin
      ex_valid_q <= 1'b0;
    end else begin
      ex_valid_q <= bus.id_valid;
      op1_q      <= val[0];
      op2_q      <= bus.id_alu_src ? bus.id_imm : val[1];
      store_q    <= val[1];
      sel1_q     <= sel[0];
      sel2_q     <= sel[1];
    end
  end

  assign bus.stall         = stall_c;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_op1        = op1_q;
  assign bus.ex_op2        = op2_q;
  assign bus.ex_store_data = store_q;
  assign bus.ex_fwd_sel1   = sel1_q;
  assign bus.ex_fwd_sel2   = sel2_q;

`ifdef FWD_STATS_EN
  logic [31:0] fwd_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (!bus.flush && !stall_c && bus.id_valid &&
          ((sel[0] != '0) || (sel[1] != '0)) && (fwd_cnt_q != '1))
        fwd_cnt_q <= fwd_cnt_q + 32'd1;
      if (stall_c && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.stat_fwd_cnt   = fwd_cnt_q;
  assign bus.stat_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_ex_operand_forward_unit.sv
module tb_ex_operand_forward_unit;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_operand_forward_unit_if #(.XLEN(XLEN), .REG_AW(REG_AW), .BYPASS_DEPTH(3)) bus3 ();
  ex_operand_forward_unit_if #(.XLEN(XLEN), .REG_AW(REG_AW), .BYPASS_DEPTH(2)) bus2 ();

  ex_operand_forward_unit #(.XLEN(XLEN), .REG_AW(REG_AW), .BYPASS_DEPTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3));
  ex_operand_forward_unit #(.XLEN(XLEN), .REG_AW(REG_AW), .BYPASS_DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  // Depth-2 instance sees identical stimulus.
  assign bus2.id_valid      = bus3.id_valid;
  assign bus2.id_rs1        = bus3.id_rs1;
  assign bus2.id_rs2        = bus3.id_rs2;
  assign bus2.id_rs1_data   = bus3.id_rs1_data;
  assign bus2.id_rs2_data   = bus3.id_rs2_data;
  assign bus2.id_imm        = bus3.id_imm;
  assign bus2.id_alu_src    = bus3.id_alu_src;
  assign bus2.flush         = bus3.flush;
  assign bus2.exmem_we      = bus3.exmem_we;
  assign bus2.exmem_rd      = bus3.exmem_rd;
  assign bus2.exmem_data    = bus3.exmem_data;
  assign bus2.exmem_is_load = bus3.exmem_is_load;
  assign bus2.memwb_we      = bus3.memwb_we;
  assign bus2.memwb_rd      = bus3.memwb_rd;
  assign bus2.memwb_data    = bus3.memwb_data;

  typedef struct packed {
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic        id_alu_src;
    logic        flush;
    logic        exmem_we;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_data;
    logic        exmem_is_load;
    logic        memwb_we;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;
  } vec_t;

  typedef struct packed {
    logic        stall;
    logic        ex_valid;
    logic        chk_ops;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] store;
    logic [1:0]  sel1;
    logic [1:0]  sel2;
    logic        chk_d2;
    logic [31:0] d2_op1;
    logic [1:0]  d2_sel1;
  } exp_t;

  typedef struct {
    vec_t v;
    exp_t e;
  } row_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic drive(input vec_t v);
    bus3.id_valid      = v.id_valid;
    bus3.id_rs1        = v.id_rs1;
    bus3.id_rs2        = v.id_rs2;
    bus3.id_rs1_data   = v.id_rs1_data;
    bus3.id_rs2_data   = v.id_rs2_data;
    bus3.id_imm        = v.id_imm;
    bus3.id_alu_src    = v.id_alu_src;
    bus3.flush         = v.flush;
    bus3.exmem_we      = v.exmem_we;
    bus3.exmem_rd      = v.exmem_rd;
    bus3.exmem_data    = v.exmem_data;
    bus3.exmem_is_load = v.exmem_is_load;
    bus3.memwb_we      = v.memwb_we;
    bus3.memwb_rd      = v.memwb_rd;
    bus3.memwb_data    = v.memwb_data;
  endtask

  // Drive one ID-slot cycle, check same-cycle stall, queue the expected EX
  // state, then compare it after the capturing edge.
  task automatic step(input string tag, input vec_t v, input exp_t e);
    exp_t x;
    @(negedge clk);
    drive(v);
    #1;
    check({tag, ".stall"}, 32'(bus3.stall), 32'(e.stall));
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s.scoreboard: got empty queue expected one entry", tag);
    end else begin
      x = sb.pop_front();
      check({tag, ".ex_valid"}, 32'(bus3.ex_valid), 32'(x.ex_valid));
      if (x.chk_ops) begin
        check({tag, ".op1"},   bus3.ex_op1, x.op1);
        check({tag, ".op2"},   bus3.ex_op2, x.op2);
        check({tag, ".store"}, bus3.ex_store_data, x.store);
        check({tag, ".sel1"},  32'(bus3.ex_fwd_sel1), 32'(x.sel1));
        check({tag, ".sel2"},  32'(bus3.ex_fwd_sel2), 32'(x.sel2));
      end
      if (x.chk_d2) begin
        check({tag, ".d2_op1"},  bus2.ex_op1, x.d2_op1);
        check({tag, ".d2_sel1"}, 32'(bus2.ex_fwd_sel1), 32'(x.d2_sel1));
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".ex_valid"}, 32'(bus3.ex_valid), 32'd0);
    check({tag, ".op1"},      bus3.ex_op1, 32'd0);
    check({tag, ".op2"},      bus3.ex_op2, 32'd0);
    check({tag, ".store"},    bus3.ex_store_data, 32'd0);
    check({tag, ".sel1"},     32'(bus3.ex_fwd_sel1), 32'd0);
    check({tag, ".sel2"},     32'(bus3.ex_fwd_sel2), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1);
  end

  initial begin
    row_t rows[7];
    vec_t z;
    z = '0;

    // R0: EX/MEM and MEM/WB both write x5; EX/MEM wins.
    rows[0].v = '{id_valid:1, id_rs1:5, id_rs2:6, id_rs1_data:32'h11, id_rs2_data:32'h66,
                  exmem_we:1, exmem_rd:5, exmem_data:32'hAAAA,
                  memwb_we:1, memwb_rd:5, memwb_data:32'hBBBB, default:0};
    rows[0].e = '{ex_valid:1, chk_ops:1, op1:32'hAAAA, op2:32'h66, store:32'h66,
                  sel1:1, sel2:0, chk_d2:1, d2_op1:32'hAAAA, d2_sel1:1, default:0};
    // R1: x0 never forwarded even though EX/MEM claims to write it.
    rows[1].v = '{id_valid:1, exmem_we:1, exmem_rd:0, exmem_data:32'hDEAD, default:0};
    rows[1].e = '{ex_valid:1, chk_ops:1, chk_d2:1, default:0};
    // R2: plain RF read while MEM/WB retires x9 = 0x55.
    rows[2].v = '{id_valid:1, id_rs1:3, id_rs2:4, id_rs1_data:32'h33, id_rs2_data:32'h44,
                  memwb_we:1, memwb_rd:9, memwb_data:32'h55, default:0};
    rows[2].e = '{ex_valid:1, chk_ops:1, op1:32'h33, op2:32'h44, store:32'h44,
                  chk_d2:1, d2_op1:32'h33, default:0};
    // R3: x9 from history (stale RF 0); depth 2 has no history.
    rows[3].v = '{id_valid:1, id_rs1:9, id_rs2:5, id_rs1_data:0, id_rs2_data:32'h77, default:0};
    rows[3].e = '{ex_valid:1, chk_ops:1, op1:32'h55, op2:32'h77, store:32'h77,
                  sel1:3, chk_d2:1, d2_op1:0, d2_sel1:0, default:0};
    // R4: immediate op2, store data forwarded from MEM/WB.
    rows[4].v = '{id_valid:1, id_rs1:1, id_rs2:8, id_rs1_data:32'h101, id_rs2_data:32'h1,
                  id_imm:32'h10, id_alu_src:1,
                  memwb_we:1, memwb_rd:8, memwb_data:32'h88, default:0};
    rows[4].e = '{ex_valid:1, chk_ops:1, op1:32'h101, op2:32'h10, store:32'h88,
                  sel2:2, chk_d2:1, d2_op1:32'h101, default:0};
    // R5: MEM/WB x8 = 0x99 beats history x8 = 0x88.
    rows[5].v = '{id_valid:1, id_rs1:8, id_rs2:8,
                  memwb_we:1, memwb_rd:8, memwb_data:32'h99, default:0};
    rows[5].e = '{ex_valid:1, chk_ops:1, op1:32'h99, op2:32'h99, store:32'h99,
                  sel1:2, sel2:2, chk_d2:1, d2_op1:32'h99, d2_sel1:2, default:0};
    // R6: idle ID slot still loads operands; x8 from history.
    rows[6].v = '{id_valid:0, id_rs1:8, id_rs2:2, id_rs2_data:32'h22, default:0};
    rows[6].e = '{ex_valid:0, chk_ops:1, op1:32'h99, op2:32'h22, store:32'h22,
                  sel1:3, chk_d2:1, d2_op1:0, d2_sel1:0, default:0};

    drive(z);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) step($sformatf("row%0d", i), rows[i].v, rows[i].e);

    // Load-use on rs2: bubble, operands hold.
    step("lu_stall",
         '{id_valid:1, id_rs1:1, id_rs2:7, id_rs1_data:32'h1,
           exmem_we:1, exmem_rd:7, exmem_data:32'hBAD, exmem_is_load:1, default:0},
         '{stall:1, ex_valid:0, chk_ops:1, op1:32'h99, op2:32'h22, store:32'h22,
           sel1:3, default:0});
    // Load now in MEM/WB.
    step("lu_release",
         '{id_valid:1, id_rs1:1, id_rs2:7, id_rs1_data:32'h1,
           memwb_we:1, memwb_rd:7, memwb_data:32'h1234, default:0},
         '{ex_valid:1, chk_ops:1, op1:32'h1, op2:32'h1234, store:32'h1234,
           sel2:2, default:0});
    // Flush together with a load-use stall.
    step("flush_stall",
         '{id_valid:1, id_rs1:1, id_rs2:7, id_rs1_data:32'h1, flush:1,
           exmem_we:1, exmem_rd:7, exmem_data:32'hBAD, exmem_is_load:1, default:0},
         '{stall:1, ex_valid:0, chk_ops:1, op1:32'h1, op2:32'h1234, store:32'h1234,
           sel2:2, default:0});
    step("flush_only",
         '{id_valid:1, id_rs1:3, id_rs1_data:32'h33, flush:1, default:0},
         '{ex_valid:0, default:0});
    // Immediate op2 with store data from EX/MEM.
    step("imm_exmem",
         '{id_valid:1, id_rs2:4, id_rs2_data:32'h40, id_imm:32'h10, id_alu_src:1,
           exmem_we:1, exmem_rd:4, exmem_data:32'h4444, default:0},
         '{ex_valid:1, chk_ops:1, op1:0, op2:32'h10, store:32'h4444, sel2:1, default:0});
    // Put x5 into history, then reset mid-stall.
    step("pre_reset",
         '{id_valid:1, id_rs1:5, id_rs1_data:32'h11,
           memwb_we:1, memwb_rd:5, memwb_data:32'h5555, default:0},
         '{ex_valid:1, chk_ops:1, op1:32'h5555, sel1:2,
           chk_d2:1, d2_op1:32'h5555, d2_sel1:2, default:0});
    @(negedge clk);
    drive('{id_valid:1, id_rs1:5, id_rs2:7, id_rs1_data:32'h11,
            exmem_we:1, exmem_rd:7, exmem_is_load:1, default:0});
    rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset",
         '{id_valid:1, id_rs1:5, id_rs1_data:32'h11, default:0},
         '{ex_valid:1, chk_ops:1, op1:32'h11, sel1:0, default:0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
